// File: rtl/pong_game_ctrl.sv
// Pong game controller: serve/play/score FSM with paddle and ball kinematics,
// advanced once per frame tick.
module pong_game_ctrl #(
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned PADDLE_W     = 8,
    parameter int unsigned PADDLE_H     = 64,
    parameter int unsigned BALL_SZ      = 8,
    parameter int unsigned P1_X         = 10,
    parameter int unsigned P2_X         = 622,
    parameter int unsigned PADDLE_SPD   = 4,
    parameter int unsigned BALL_SPD     = 2,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned WIN_SCORE    = 9
) (
    input  logic       i_CLK,
    input  logic       i_RST,
    input  logic       i_frame_tick,
    input  logic       i_p1_up,
    input  logic       i_p1_dn,
    input  logic       i_p2_up,
    input  logic       i_p2_dn,
    input  logic       i_start,
    output logic [9:0] o_p1_y,
    output logic [9:0] o_p2_y,
    output logic [9:0] o_ball_x,
    output logic [9:0] o_ball_y,
    output logic [3:0] o_score1,
    output logic [3:0] o_score2,
    output logic [1:0] o_state,
    output logic       o_game_over
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SERVE = 2'd1;
    localparam logic [1:0] ST_PLAY  = 2'd2;
    localparam logic [1:0] ST_OVER  = 2'd3;

    localparam int unsigned CW  = 11;
    localparam int unsigned SCW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

    localparam logic [CW-1:0] H_B     = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_B     = CW'(V_ACTIVE);
    localparam logic [CW-1:0] SZ_B    = CW'(BALL_SZ);
    localparam logic [CW-1:0] PH_B    = CW'(PADDLE_H);
    localparam logic [CW-1:0] PSPD_B  = CW'(PADDLE_SPD);
    localparam logic [CW-1:0] BSPD_B  = CW'(BALL_SPD);
    localparam logic [CW-1:0] L_EDGE  = CW'(P1_X + PADDLE_W);
    localparam logic [CW-1:0] P2X_B   = CW'(P2_X);
    localparam logic [CW-1:0] R_EDGE  = CW'(P2_X - BALL_SZ);
    localparam logic [CW-1:0] Y_MAX   = CW'(V_ACTIVE - PADDLE_H);
    localparam logic [CW-1:0] BALL_X0 = CW'((H_ACTIVE - BALL_SZ) / 2);
    localparam logic [CW-1:0] BALL_Y0 = CW'((V_ACTIVE - BALL_SZ) / 2);
    localparam logic [CW-1:0] PAD_Y0  = CW'((V_ACTIVE - PADDLE_H) / 2);
    localparam logic [SCW-1:0] SERVE_LAST = SCW'(SERVE_FRAMES - 1);
    localparam logic [3:0]    WIN_B   = 4'(WIN_SCORE);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] p1_y_q, p1_y_d, p2_y_q, p2_y_d;
    logic [CW-1:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic          dx_q, dx_d, dy_q, dy_d;
    logic [3:0]    score1_q, score1_d, score2_q, score2_d;
    logic [SCW-1:0] cnt_q, cnt_d;
    logic          game_over_q;
    logic          run_q;

    logic          tick_en;
    logic          ov1, ov2;
    logic          serve_en, serve_dx;

    // One paddle step with clamping to the playfield
    function automatic logic [CW-1:0] paddle_next(input logic [CW-1:0] y,
                                                  input logic up, input logic dn);
        paddle_next = y;
        if (up && !dn) begin
            paddle_next = (y < PSPD_B) ? '0 : y - PSPD_B;
        end else if (dn && !up) begin
            paddle_next = (y + PSPD_B > Y_MAX) ? Y_MAX : y + PSPD_B;
        end
    endfunction

    assign tick_en = i_frame_tick && run_q;

    // Next-state logic: FSM, paddles, ball and scoring on each accepted tick
    always_comb begin
        state_d  = state_q;
        p1_y_d   = p1_y_q;
        p2_y_d   = p2_y_q;
        ball_x_d = ball_x_q;
        ball_y_d = ball_y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        score1_d = score1_q;
        score2_d = score2_q;
        cnt_d    = cnt_q;
        serve_en = 1'b0;
        serve_dx = 1'b1;
        // overlap uses paddle positions from before this tick's move
        ov1 = (ball_y_q + SZ_B > p1_y_q) && (ball_y_q < p1_y_q + PH_B);
        ov2 = (ball_y_q + SZ_B > p2_y_q) && (ball_y_q < p2_y_q + PH_B);

        if (tick_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        state_d  = ST_SERVE;
                        serve_en = 1'b1;
                    end
                end
                ST_SERVE: begin
                    p1_y_d = paddle_next(p1_y_q, i_p1_up, i_p1_dn);
                    p2_y_d = paddle_next(p2_y_q, i_p2_up, i_p2_dn);
                    if (cnt_q == SERVE_LAST) begin
                        state_d = ST_PLAY;
                    end else begin
                        cnt_d = cnt_q + SCW'(1);
                    end
                end
                ST_PLAY: begin
                    p1_y_d = paddle_next(p1_y_q, i_p1_up, i_p1_dn);
                    p2_y_d = paddle_next(p2_y_q, i_p2_up, i_p2_dn);
                    // vertical axis: walls
                    if (!dy_q) begin
                        if (ball_y_q < BSPD_B) begin
                            ball_y_d = '0;
                            dy_d     = 1'b1;
                        end else begin
                            ball_y_d = ball_y_q - BSPD_B;
                        end
                    end else if (ball_y_q + SZ_B + BSPD_B > V_B) begin
                        ball_y_d = V_B - SZ_B;
                        dy_d     = 1'b0;
                    end else begin
                        ball_y_d = ball_y_q + BSPD_B;
                    end
                    // horizontal axis: paddle hit wins over a miss
                    if (!dx_q) begin
                        if (ball_x_q <= L_EDGE + BSPD_B && ball_x_q >= L_EDGE && ov1) begin
                            ball_x_d = L_EDGE;
                            dx_d     = 1'b1;
                        end else if (ball_x_q < BSPD_B) begin
                            score2_d = (score2_q < WIN_B) ? score2_q + 4'd1 : score2_q;
                            state_d  = (score2_d == WIN_B) ? ST_OVER : ST_SERVE;
                            serve_en = 1'b1;
                            serve_dx = 1'b0;
                        end else begin
                            ball_x_d = ball_x_q - BSPD_B;
                        end
                    end else begin
                        if (ball_x_q + SZ_B + BSPD_B >= P2X_B && ball_x_q + SZ_B <= P2X_B && ov2) begin
                            ball_x_d = R_EDGE;
                            dx_d     = 1'b0;
                        end else if (ball_x_q + SZ_B + BSPD_B > H_B) begin
                            score1_d = (score1_q < WIN_B) ? score1_q + 4'd1 : score1_q;
                            state_d  = (score1_d == WIN_B) ? ST_OVER : ST_SERVE;
                            serve_en = 1'b1;
                            serve_dx = 1'b1;
                        end else begin
                            ball_x_d = ball_x_q + BSPD_B;
                        end
                    end
                end
                default: begin
                    if (i_start) begin
                        state_d  = ST_SERVE;
                        score1_d = '0;
                        score2_d = '0;
                        serve_en = 1'b1;
                    end
                end
            endcase

            // any miss or start recentres the ball; it also stays centred while OVER
            if (serve_en) begin
                ball_x_d = BALL_X0;
                ball_y_d = BALL_Y0;
                cnt_d    = '0;
                dx_d     = serve_dx;
                dy_d     = 1'b1;
            end
        end
    end

    // Game state registers
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q     <= ST_IDLE;
            p1_y_q      <= PAD_Y0;
            p2_y_q      <= PAD_Y0;
            ball_x_q    <= BALL_X0;
            ball_y_q    <= BALL_Y0;
            dx_q        <= 1'b1;
            dy_q        <= 1'b1;
            score1_q    <= '0;
            score2_q    <= '0;
            cnt_q       <= '0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            p1_y_q      <= p1_y_d;
            p2_y_q      <= p2_y_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            cnt_q       <= cnt_d;
            game_over_q <= (state_d == ST_OVER);
        end
    end

    // Blocks the tick in the first cycle after reset release
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    assign o_p1_y      = 10'(p1_y_q);
    assign o_p2_y      = 10'(p2_y_q);
    assign o_ball_x    = 10'(ball_x_q);
    assign o_ball_y    = 10'(ball_y_q);
    assign o_score1    = score1_q;
    assign o_score2    = score2_q;
    assign o_state     = state_q;
    assign o_game_over = game_over_q;

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- H_ACTIVE, 640, visible width (px)
- V_ACTIVE, 480, visible height (px)
- PADDLE_W, 8, paddle width
- PADDLE_H, 64, paddle height
- BALL_SZ, 8, ball side
- P1_X, 10, left paddle x
- P2_X, 622, right paddle x
- PADDLE_SPD, 4, paddle px/frame
- BALL_SPD, 2, ball px/frame per axis
- SERVE_FRAMES, 60, serve delay
- WIN_SCORE, 9, winning score
REQ-002 SHALL have ports (name, direction, width, meaning):
- i_CLK, in, 1, system clock
- i_RST, in, 1, asynchronous active-high reset
- i_frame_tick, in, 1, one-cycle pulse once per frame, issued during vertical blanking
- i_p1_up / i_p1_dn / i_p2_up / i_p2_dn, in, 1 each, synchronized, level-sensitive buttons
- i_start, in, 1, start/restart request, level-sensitive
- o_p1_y / o_p2_y, out, 10 each, paddle top-left y
- o_ball_x / o_ball_y, out, 10 each, ball top-left position
- o_score1 / o_score2, out, 4 each, scores
- o_state, out, 2, FSM state: IDLE=0, SERVE=1, PLAY=2, OVER=3
- o_game_over, out, 1, high iff state is OVER

Function
REQ-003 SHALL register all outputs; state updates occur only in cycles with i_frame_tick=1; outputs reflect each update one cycle after the tick.
REQ-004 SHALL implement the FSM:
- IDLE -> SERVE on tick with i_start=1
- SERVE -> PLAY after SERVE_FRAMES ticks
- PLAY -> SERVE on a miss
- PLAY -> OVER when a score reaches WIN_SCORE
- OVER -> SERVE on tick with i_start=1; both scores cleared
REQ-005 SHALL, on entry to SERVE, place the ball at ((H_ACTIVE-BALL_SZ)/2, (V_ACTIVE-BALL_SZ)/2) = (316, 236), zero the serve counter, and hold the ball stationary until PLAY.
REQ-006 SHALL set the serve direction toward the player who conceded; the first serve after IDLE or OVER goes right; vertical direction is always down at serve.
REQ-007 SHALL move each paddle by PADDLE_SPD per tick in SERVE and PLAY:
- up decrements y, down increments y
- both or neither pressed -> no move
- clamp to [0, V_ACTIVE-PADDLE_H]: at y=2 with up pressed, y becomes 0
- paddles frozen in IDLE and OVER
REQ-008 SHALL, in PLAY, move the ball by BALL_SPD per axis per tick using direction bits dx and dy.
REQ-009 SHALL resolve vertical wall contact:
- moving up with y<BALL_SPD -> y=0, dy=down
- moving down with y+BALL_SZ+BALL_SPD>V_ACTIVE -> y=V_ACTIVE-BALL_SZ, dy=up
REQ-010 SHALL resolve a left-paddle hit when moving left, x-BALL_SPD <= P1_X+PADDLE_W, x >= P1_X+PADDLE_W, and ball_y+BALL_SZ > p1_y and ball_y < p1_y+PADDLE_H:
- x=P1_X+PADDLE_W, dx=right
- the right paddle is handled symmetrically, with x=P2_X-BALL_SZ
REQ-011 SHALL detect a miss:
- moving left with x<BALL_SPD -> score2+1
- moving right with x+BALL_SZ+BALL_SPD>H_ACTIVE -> score1+1
- next state is SERVE, or OVER if the new score equals WIN_SCORE
REQ-012 SHALL prioritise paddle hit over miss when both conditions hold on the same tick; wall and paddle contacts on the same tick both apply, one per axis.
REQ-013 SHALL compute all comparisons with at least 11-bit unsigned arithmetic so no intermediate sum wraps.
REQ-014 SHALL evaluate paddle overlap using paddle positions from before the current tick's paddle move.
REQ-015 SHALL saturate scores at WIN_SCORE; scores never wrap.

Reset
REQ-016 SHALL, while i_RST=1 (asynchronous, active-high, effective mid-frame), force:
- state IDLE
- o_p1_y = o_p2_y = 208
- ball at (316, 236)
- scores 0, o_game_over=0
- dx=right, dy=down, serve counter 0
REQ-017 SHALL ignore i_frame_tick in the cycle reset deasserts; normal operation resumes from the next tick.

Verification
REQ-018 Reset mid-PLAY: assert i_RST with the ball at (100, 50) -> all outputs show REQ-016 values immediately, with no clock edge required.
REQ-019 Start/serve: i_start=1 on a tick from IDLE, then 60 ticks -> o_state=2; the next tick gives o_ball_x=318, o_ball_y=238.
REQ-020 Paddle clamp: hold i_p1_up for 60 ticks from y=208 -> o_p1_y reaches 0 after 52 ticks and stays 0; pressing up and down together gives no change.
REQ-021 Paddle bounce: ball at x=20 moving left, y=220, p1_y=208 -> after one tick x=18 and dx=right; with p1_y=0 instead, the ball continues toward the edge and scores, giving score2=1 and state SERVE.
REQ-022 Wall bounce: ball y=1 moving up -> y=0, dy=down; ball y=471 moving down -> y=472, dy=up.
REQ-023 Game over: score1=8 plus a right-side miss -> score1=9, o_state=3, o_game_over=1; then i_start on a tick -> scores 0, state SERVE.
